// File: rtl/parity_frame_sequencer.sv
// Tags each streamed word with its parity, accumulates frame parity, and appends a
// trailer beat carrying the word count and frame parity after every frame.
module parity_frame_sequencer #(
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              odd_mode_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_parity_o,
    output logic              m_trailer_o,
    output logic              overflow_o
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, TRAILER} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             odd_latched;

    logic             out_free;
    logic             accept;
    logic             frame_start;
    logic             odd_eff;
    logic             word_par;
    logic             acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             at_max;

    assign out_free  = !m_valid_o || m_ready_i;
    assign s_ready_o = (state != TRAILER) && out_free;
    assign accept    = s_valid_i && s_ready_o;

    // The first word of a frame restarts count/parity and samples the parity mode.
    assign frame_start = (state == IDLE);
    assign odd_eff     = frame_start ? odd_mode_i : odd_latched;
    assign word_par    = ^s_data_i;
    assign acc_next    = (frame_start ? 1'b0 : acc) ^ word_par;
    assign cnt_next    = (frame_start ? '0 : cnt) + CNT_W'(1);
    assign at_max      = (cnt_next == CNT_W'(MAX_LEN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= 1'b0;
            odd_latched <= 1'b0;
            m_valid_o   <= 1'b0;
            m_data_o    <= '0;
            m_parity_o  <= 1'b0;
            m_trailer_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            overflow_o <= 1'b0;
            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        m_valid_o   <= 1'b1;
                        m_data_o    <= s_data_i;
                        m_parity_o  <= word_par ^ odd_eff;
                        m_trailer_o <= 1'b0;
                        odd_latched <= odd_eff;
                        acc         <= acc_next;
                        cnt         <= cnt_next;
                        if (s_last_i || at_max) begin
                            state      <= TRAILER;
                            overflow_o <= !s_last_i;
                        end else begin
                            state <= DATA;
                        end
                    end else if (m_ready_i) begin
                        m_valid_o <= 1'b0;
                    end
                end
                TRAILER: begin
                    // Input is stalled here, so the trailer always follows the last data beat.
                    if (out_free) begin
                        m_valid_o   <= 1'b1;
                        m_data_o    <= DATA_W'(cnt);
                        m_parity_o  <= acc ^ odd_latched;
                        m_trailer_o <= 1'b1;
                        cnt         <= '0;
                        acc         <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Bench for parity_frame_sequencer: frame-level scoreboard model, directed cases and
// randomized traffic with random output backpressure.
module tb_parity_frame_sequencer;

    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              tr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              odd_mode = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid_o;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data_o;
    logic              m_parity_o;
    logic              m_trailer_o;
    logic              overflow_o;

    parity_frame_sequencer #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .odd_mode_i (odd_mode),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data),
        .s_last_i   (s_last),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data_o),
        .m_parity_o (m_parity_o),
        .m_trailer_o(m_trailer_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    ovf_seen = 0;
    bit    rand_ready = 1'b0;
    bit    rdy_force = 1'b0;

    // model state: expected output beats in order, plus frame bookkeeping
    beat_t exp_q[$];
    beat_t got_q[$];
    bit    in_frame = 1'b0;
    bit    trailer_owed = 1'b0;
    bit    exp_ovf = 1'b0;
    bit    hold = 1'b0;
    beat_t held;
    beat_t cur;
    beat_t want;
    int    f_cnt = 0;
    bit    f_acc = 1'b0;
    bit    f_odd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    // Monitor/scoreboard: mid-cycle, everything that will happen at the next edge is visible.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            in_frame     = 1'b0;
            trailer_owed = 1'b0;
            exp_ovf      = 1'b0;
            hold         = 1'b0;
        end else begin
            chk("overflow", 32'(overflow_o), 32'(exp_ovf));
            exp_ovf = 1'b0;
            if (overflow_o) ovf_seen++;
            chk("s_ready", 32'(s_ready_o), 32'(!trailer_owed && (!m_valid_o || m_ready)));
            cur = '{m_data_o, m_parity_o, m_trailer_o};
            if (hold) begin
                chk("hold_valid", 32'(m_valid_o), 32'd1);
                chk("hold_beat", 32'(cur), 32'(held));
            end
            if (m_valid_o && m_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    chk("beat", 32'(cur), 32'(want));
                end
                got_q.push_back(cur);
            end
            hold = m_valid_o && !m_ready;
            held = cur;
            if (trailer_owed && (!m_valid_o || m_ready)) trailer_owed = 1'b0;
            if (s_valid && s_ready_o) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    f_cnt    = 0;
                    f_acc    = 1'b0;
                    f_odd    = odd_mode;
                end
                f_cnt++;
                f_acc = f_acc ^ (^s_data);
                exp_q.push_back('{s_data, (^s_data) ^ f_odd, 1'b0});
                if (s_last || f_cnt == MAX_LEN) begin
                    exp_q.push_back('{DATA_W'(f_cnt), f_acc ^ f_odd, 1'b1});
                    trailer_owed = 1'b1;
                    in_frame     = 1'b0;
                    exp_ovf      = !s_last;
                end
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input bit last, input bit odd, output int waits);
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        odd_mode = odd;
        waits    = 0;
        forever begin
            @(negedge clk);
            waits++;
            if (s_ready_o) break;
            if (waits >= 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: word 0x%0h not accepted in %0d cycles", d, waits);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        s_valid = 1'b0;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !trailer_owed && !m_valid_o) break;
        end
        if (t >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input string name, input int i, input logic [DATA_W-1:0] d,
                            input logic p, input logic t);
        beat_t e;
        e = '{d, p, t};
        if (i < got_q.size()) chk(name, 32'(got_q[i]), 32'(e));
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: beat %0d missing, got %0d beats", name, i, got_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w2;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'd0);
        chk("rst_m_parity", 32'(m_parity_o), 32'd0);
        chk("rst_m_trailer", 32'(m_trailer_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        idle(2);
        chk("idle_s_ready", 32'(s_ready_o), 32'd1);

        // 1) single-word frame
        got_q.delete();
        send(16'h0001, 1, 0, w);
        drain();
        chk("t1_nbeats", 32'(got_q.size()), 32'd2);
        exp_beat("t1_data", 0, 16'h0001, 1, 0);
        exp_beat("t1_trl", 1, 16'h0001, 1, 1);

        // 2) even two-word frame
        got_q.delete();
        send(16'h0003, 0, 0, w);
        send(16'h0007, 1, 0, w);
        drain();
        exp_beat("t2_d0", 0, 16'h0003, 0, 0);
        exp_beat("t2_d1", 1, 16'h0007, 1, 0);
        exp_beat("t2_trl", 2, 16'h0002, 1, 1);

        // 3) odd parity frame; mode changes mid-frame are ignored
        got_q.delete();
        send(16'h0000, 0, 1, w);
        send(16'hFFFF, 1, 0, w);
        drain();
        exp_beat("t3_d0", 0, 16'h0000, 1, 0);
        exp_beat("t3_d1", 1, 16'hFFFF, 1, 0);
        exp_beat("t3_trl", 2, 16'h0002, 1, 1);

        // 4) forced close at MAX_LEN, fifth word opens a new frame
        got_q.delete();
        ovf_seen = 0;
        repeat (5) send(16'h0001, 0, 0, w);
        send(16'h0001, 1, 0, w);
        drain();
        chk("t4_ovf_count", 32'(ovf_seen), 32'd1);
        for (int i = 0; i < 4; i++) exp_beat("t4_d", i, 16'h0001, 1, 0);
        exp_beat("t4_trl", 4, 16'h0004, 0, 1);
        exp_beat("t4_d5", 5, 16'h0001, 1, 0);
        exp_beat("t4_d6", 6, 16'h0001, 1, 0);
        exp_beat("t4_trl2", 7, 16'h0002, 0, 1);

        // 5) backpressure holds the beat, then full throughput
        got_q.delete();
        rdy_force = 1'b0;
        idle(1);
        send(16'hA5A5, 0, 0, w);
        s_valid = 1'b1;
        s_data  = 16'h1111;
        s_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_held_valid", 32'(m_valid_o), 32'd1);
            chk("t5_held_data", 32'(m_data_o), 32'h0000A5A5);
            chk("t5_stall_ready", 32'(s_ready_o), 32'd0);
        end
        rdy_force = 1'b1;
        send(16'h1111, 0, 0, w);
        send(16'h2222, 1, 0, w2);
        chk("t5_b2b_w1", 32'(w), 32'd1);
        chk("t5_b2b_w2", 32'(w2), 32'd1);
        drain();
        chk("t5_nbeats", 32'(got_q.size()), 32'd4);
        exp_beat("t5_d0", 0, 16'hA5A5, 0, 0);
        exp_beat("t5_d1", 1, 16'h1111, 0, 0);
        exp_beat("t5_d2", 2, 16'h2222, 0, 0);
        exp_beat("t5_trl", 3, 16'h0003, 0, 1);

        // 6) reset while the trailer is pending
        rdy_force = 1'b0;
        idle(1);
        send(16'h0001, 1, 0, w);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid_o), 32'd0);
        idle(2);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        idle(2);
        got_q.delete();
        send(16'h0001, 1, 0, w);
        drain();
        chk("t6_nbeats", 32'(got_q.size()), 32'd2);
        exp_beat("t6_d0", 0, 16'h0001, 1, 0);
        exp_beat("t6_trl", 1, 16'h0001, 1, 1);

        // 7) last exactly at MAX_LEN: normal close, no overflow
        got_q.delete();
        ovf_seen = 0;
        send(16'h8000, 0, 1, w);
        send(16'h0003, 0, 1, w);
        send(16'h0101, 0, 1, w);
        send(16'h0007, 1, 1, w);
        drain();
        chk("t7_ovf_count", 32'(ovf_seen), 32'd0);
        exp_beat("t7_d0", 0, 16'h8000, 0, 0);
        exp_beat("t7_d3", 3, 16'h0007, 0, 0);
        exp_beat("t7_trl", 4, 16'h0004, 1, 1);

        // randomized traffic under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(16'($urandom), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), w);
        end
        s_valid = 1'b0;
        s_last  = 1'b1;
        send(16'($urandom), 1, 0, w);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
